wb_mem_responder: RTL and testbench

- Wishbone classic (B4, non-pipelined) slave memory that answers the processor's data-port master in simulation and FPGA test harnesses.
- Holds a byte-addressable word array with byte-lane writes and a configurable wait-state count.
- Flags out-of-range accesses with an error response.
- Sits between a core's dport master and the controller, or stands alone in benches.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_mem_array.sv | 36 +++
 rtl/wb_mem_responder.sv | 117 +++++++++++
 tb/tb_wb_mem_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : Wishbone bus widths, responder FSM states and captured request type
// Rev 1.0
// ============================================================================
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_resp_state_t;

  typedef struct packed {
    logic                we;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_mem_array.sv
`default_nettype none
// ============================================================================
// wb_mem_array : byte-enabled synchronous single-port RAM
// Rev 1.0
// ============================================================================
module wb_mem_array
  import wb_pkg::*;
#(
  parameter int    DEPTH     = 4096,
  parameter int    AW        = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic                sys_clk,
  input  logic                en,
  input  logic [WB_SEL_W-1:0] we_be,
  input  logic [AW-1:0]       addr,
  input  logic [WB_DAT_W-1:0] wdata,
  output logic [WB_DAT_W-1:0] rdata
);

  logic [WB_DAT_W-1:0] mem_q [DEPTH];
  logic [WB_DAT_W-1:0] rdata_q;

  always_ff @(posedge sys_clk) begin
    if (en) begin
      for (int i = 0; i < WB_SEL_W; i++) begin
        if (we_be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/wb_mem_responder.sv
`default_nettype none
// ============================================================================
// wb_mem_responder : Wishbone classic slave memory with wait states and errors
// Rev 1.0
// ============================================================================
module wb_mem_responder
  import wb_pkg::*;
#(
  parameter int                  MEM_WORDS   = 4096,
  parameter logic [WB_ADR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                  WAIT_STATES = 1,
  parameter string               INIT_FILE   = ""
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [WB_SEL_W-1:0] wb_sel_i,
  input  logic [WB_ADR_W-1:0] wb_adr_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o
);

  localparam int              AW        = $clog2(MEM_WORDS);
  localparam logic [WB_ADR_W:0] MEM_BYTES = (WB_ADR_W + 1)'(MEM_WORDS) << 2;
  localparam logic [3:0]      CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_resp_state_t      state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  wb_req_t             req_q, req_d, live_req, cur_req;
  logic                ack_q, ack_d, err_q, err_d, rd_q, rd_d;
  logic                mem_go;
  logic [WB_ADR_W-1:0] offset;
  logic                in_range;
  logic [WB_DAT_W-1:0] rdata;

  assign live_req = {wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cur_req = req_q;
    mem_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          req_d = live_req;
          // Zero wait states: the access happens on the capture edge itself.
          if (WAIT_STATES == 0) begin
            cur_req = live_req;
            mem_go  = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i)            state_d = IDLE;
        else if (cnt_q == 4'd0)   mem_go  = 1'b1;
        else                      cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    offset   = cur_req.adr - BASE_ADDR;
    in_range = {1'b0, offset} < MEM_BYTES;
    if (mem_go) state_d = RESP;
    ack_d = mem_go && in_range;
    err_d = mem_go && !in_range;
    rd_d  = ack_d && !cur_req.we;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  wb_mem_array #(
    .DEPTH     (MEM_WORDS),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .sys_clk (sys_clk),
    .en      (mem_go && in_range),
    .we_be   (cur_req.we ? cur_req.sel : '0),
    .addr    (offset[AW+1:2]),
    .wdata   (cur_req.dat),
    .rdata   (rdata)
  );

  // RAM output register has no reset; qualifying it with a reset flop keeps
  // wb_dat_o at zero outside read-ack cycles and under reset.
  assign wb_dat_o = rd_q ? rdata : '0;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_wb_mem_responder : directed vectors for wb_mem_responder (1 and 2 waits)
// Rev 1.0
// ============================================================================
module tb_wb_mem_responder;

  logic        sys_clk;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic [31:0] dat1, dat2;
  logic        ack1, err1, ack2, err2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  wb_mem_responder #(
    .MEM_WORDS(4096), .BASE_ADDR(32'h0), .WAIT_STATES(1), .INIT_FILE("")
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1)
  );

  wb_mem_responder #(
    .MEM_WORDS(4096), .BASE_ADDR(32'h0), .WAIT_STATES(2), .INIT_FILE("")
  ) dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_dat_o(dat2), .wb_ack_o(ack2), .wb_err_o(err2)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request; bus held for two cycles so the 2-wait instance also
  // completes. Checks the 1-wait instance on every cycle of the transfer.
  task automatic run_vec(input vec_t v, input int idx);
    cyc = 1'b1; stb = 1'b1; we = v.we; sel = v.sel; adr = v.adr; dat_i = v.dat;
    for (int k = 0; k < 4; k++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("v%0d ack k%0d", idx, k), {31'b0, ack1}, (k == 1) ? {31'b0, v.exp_ack} : 32'd0);
      chk($sformatf("v%0d err k%0d", idx, k), {31'b0, err1}, (k == 1) ? {31'b0, v.exp_err} : 32'd0);
      chk($sformatf("v%0d dat k%0d", idx, k), dat1, (k == 1) ? v.exp_dat : 32'd0);
      if (k == 0) begin dat_i = ~v.dat; sel = ~v.sel; end
      if (k == 2) begin cyc = 1'b0; stb = 1'b0; end
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [3:0] s, input logic [31:0] a,
                              input logic [31:0] d, input logic ea, input logic ee,
                              input logic [31:0] ed);
    vec_t v;
    v.we = w; v.sel = s; v.adr = a; v.dat = d;
    v.exp_ack = ea; v.exp_err = ee; v.exp_dat = ed;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(1, 4'hF, 32'h0000_0000, 32'h1122_3344, 1, 0, 32'h0);
    vecs[1]  = mk(1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1, 0, 32'h0);
    vecs[2]  = mk(0, 4'hF, 32'h0000_0010, 32'h0,         1, 0, 32'hDEAD_BEEF);
    vecs[3]  = mk(1, 4'h2, 32'h0000_0010, 32'h0000_AA00, 1, 0, 32'h0);
    vecs[4]  = mk(0, 4'h0, 32'h0000_0010, 32'h0,         1, 0, 32'hDEAD_AAEF);
    vecs[5]  = mk(1, 4'hF, 32'h0000_0014, 32'hCAFE_F00D, 1, 0, 32'h0);
    vecs[6]  = mk(1, 4'h0, 32'h0000_0014, 32'hFFFF_FFFF, 1, 0, 32'h0);
    vecs[7]  = mk(0, 4'hF, 32'h0000_0014, 32'h0,         1, 0, 32'hCAFE_F00D);
    vecs[8]  = mk(1, 4'hF, 32'h0000_4000, 32'hFFFF_FFFF, 0, 1, 32'h0);
    vecs[9]  = mk(0, 4'hF, 32'h0000_4000, 32'h0,         0, 1, 32'h0);
    vecs[10] = mk(0, 4'hF, 32'h0000_0000, 32'h0,         1, 0, 32'h1122_3344);
    vecs[11] = mk(1, 4'hF, 32'h0000_3FFC, 32'h0102_0304, 1, 0, 32'h0);
    vecs[12] = mk(0, 4'hF, 32'h0000_3FFF, 32'h0,         1, 0, 32'h0102_0304);
    vecs[13] = mk(0, 4'hF, 32'hFFFF_FFFC, 32'h0,         0, 1, 32'h0);
    vecs[14] = mk(1, 4'hF, 32'h0000_0020, 32'h0BAD_F00D, 1, 0, 32'h0);
    vecs[15] = mk(1, 4'hF, 32'h0000_0030, 32'h55AA_55AA, 1, 0, 32'h0);
    vecs[16] = mk(1, 4'h9, 32'h0000_3FFC, 32'hAA00_00BB, 1, 0, 32'h0);
    vecs[17] = mk(0, 4'hF, 32'h0000_3FFC, 32'h0,         1, 0, 32'hAA02_03BB);

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
    #1;
    chk("reset ack", {31'b0, ack1}, 32'd0);
    chk("reset err", {31'b0, err1}, 32'd0);
    chk("reset dat", dat1, 32'd0);
    chk("reset ack2", {31'b0, ack2}, 32'd0);
    chk("reset err2", {31'b0, err2}, 32'd0);
    chk("reset dat2", dat2, 32'd0);
    @(posedge sys_clk); @(posedge sys_clk); #4;
    rst_n = 1'b1;
    @(posedge sys_clk); #1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Abort: cyc drops while both instances are waiting.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h20; dat_i = 32'h1234_5678;
    @(posedge sys_clk); #1;
    cyc = 1'b0; stb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("abort ack k%0d", k), {31'b0, ack1 | ack2}, 32'd0);
      chk($sformatf("abort err k%0d", k), {31'b0, err1 | err2}, 32'd0);
    end
    run_vec(mk(0, 4'hF, 32'h20, 32'h0, 1, 0, 32'h0BAD_F00D), 100);

    // Reset while a write to 0x30 is in WAIT.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h30; dat_i = 32'hFFFF_FFFF;
    @(posedge sys_clk); #3;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    #1;
    chk("rstwait ack", {31'b0, ack1}, 32'd0);
    chk("rstwait err", {31'b0, err1}, 32'd0);
    @(posedge sys_clk); #4;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("rstwait post ack k%0d", k), {31'b0, ack1 | ack2}, 32'd0);
    end
    run_vec(mk(0, 4'hF, 32'h30, 32'h0, 1, 0, 32'h55AA_55AA), 101);

    // Reset during a read response: outputs must clear before the next edge.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h10; dat_i = 32'h0;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    chk("rstresp pre ack", {31'b0, ack1}, 32'd1);
    chk("rstresp pre dat", dat1, 32'hDEAD_AAEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstresp ack", {31'b0, ack1}, 32'd0);
    chk("rstresp err", {31'b0, err1}, 32'd0);
    chk("rstresp dat", dat1, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge sys_clk); #4;
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    chk("rstresp post ack", {31'b0, ack1 | ack2}, 32'd0);

    // Back-to-back reads with cyc/stb held: 2-wait instance acks every 4 cycles.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h10; dat_i = 32'h0;
    for (int k = 0; k < 12; k++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("b2b ack2 k%0d", k), {31'b0, ack2}, (k % 4 == 2) ? 32'd1 : 32'd0);
      chk($sformatf("b2b err2 k%0d", k), {31'b0, err2}, 32'd0);
      chk($sformatf("b2b dat2 k%0d", k), dat2, (k % 4 == 2) ? 32'hDEAD_AAEF : 32'd0);
      chk($sformatf("b2b ack1 k%0d", k), {31'b0, ack1}, (k % 3 == 1) ? 32'd1 : 32'd0);
      if (k == 10) begin cyc = 1'b0; stb = 1'b0; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
